// File: rtl/fx2fp_pkg.sv
// Shared binary32 field widths, packed float layout and the round-to-nearest-even
// decision used by the fixed-point to float converter.
package fx2fp_pkg;

    localparam int F32_BIAS   = 127;
    localparam int F32_MANT_W = 23;
    localparam int F32_EXP_W  = 8;

    typedef struct packed {
        logic                  sign;
        logic [F32_EXP_W-1:0]  exp;
        logic [F32_MANT_W-1:0] mant;
    } float32_t;

    // Round up only above the halfway point, or exactly on it when the kept lsb is odd.
    function automatic logic rne_round(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/fx2fp_lzc.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
module fx2fp_lzc #(
    parameter  int W     = 32,
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_zero = ~|i_vec;

endmodule

// File: rtl/fixedp2floatp_pipe.sv
// Three-stage signed fixed-point to IEEE-754 binary32 converter with RNE rounding and
// valid/ready flow control. Define FX2FP_INEXACT_EN to add the out_inexact flag.
module fixedp2floatp_pipe
    import fx2fp_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0] in_fixed,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_float
`ifdef FX2FP_INEXACT_EN
    ,
    output logic                          out_inexact
`endif
);

    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    logic w_advance;

    logic w_sign;
    logic [W-1:0] w_mag;
    logic r_s1Valid;
    logic r_s1Sign;
    logic [W-1:0] r_s1Mag;

    logic [IDX_W-1:0] w_idx;
    logic w_zero;
    logic [IDX_W-1:0] w_shift;
    logic [W-2:0] w_frac;
    logic r_s2Valid;
    logic r_s2Sign;
    logic r_s2Zero;
    logic [IDX_W-1:0] r_s2Idx;
    logic [W-2:0] r_s2Frac;

    logic [W+24:0] w_ext;
    logic [22:0] w_mant;
    logic w_guard;
    logic w_sticky;
    logic w_roundUp;
    logic [23:0] w_mantSum;
    logic w_carry;
    float32_t w_result;
    logic r_s3Valid;
    float32_t r_s3Float;

    // The whole pipe moves as one unit whenever the output slot is free or being drained.
    assign w_advance = ~r_s3Valid | out_ready;
    assign in_ready  = w_advance;

    assign w_sign = in_fixed[W-1];
    assign w_mag  = w_sign ? -in_fixed : in_fixed;

    fx2fp_lzc #(.W(W)) u_lzc (
        .i_vec  (r_s1Mag),
        .o_idx  (w_idx),
        .o_zero (w_zero)
    );

    // The hidden bit is implied after normalisation, so only the bits below it are kept.
    assign w_shift = IDX_W'(W - 1) - w_idx;
    assign w_frac  = (W-1)'(r_s1Mag << w_shift);

    // Zero padding lets narrow words share the same mantissa/guard/sticky slicing.
    assign w_ext     = {r_s2Frac, 26'd0};
    assign w_mant    = w_ext[W+24 -: 23];
    assign w_guard   = w_ext[W+1];
    assign w_sticky  = |w_ext[W:0];
    assign w_roundUp = rne_round(w_mant[0], w_guard, w_sticky);
    assign w_mantSum = {1'b0, w_mant} + 24'(w_roundUp);
    assign w_carry   = w_mantSum[23];

    always_comb begin
        w_result = '0;
        if (!r_s2Zero) begin
            w_result.sign = r_s2Sign;
            w_result.exp  = 8'(F32_BIAS + int'(r_s2Idx) - FRAC_BITS + int'(w_carry));
            w_result.mant = w_mantSum[22:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s3Valid <= 1'b0;
        end else if (w_advance) begin
            r_s1Valid <= in_valid;
            r_s2Valid <= r_s1Valid;
            r_s3Valid <= r_s2Valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1Sign <= w_sign;
            r_s1Mag  <= w_mag;
            r_s2Sign <= r_s1Sign;
            r_s2Zero <= w_zero;
            r_s2Idx  <= w_idx;
            r_s2Frac <= w_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3Float <= '0;
        end else if (w_advance) begin
            r_s3Float <= w_result;
        end
    end

    assign out_valid = r_s3Valid;
    assign out_float = r_s3Float;

`ifdef FX2FP_INEXACT_EN
    logic r_s3Inexact;

    // Gated by the stage valid so a bubble in the output slot never reports inexact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3Inexact <= 1'b0;
        end else if (w_advance) begin
            r_s3Inexact <= r_s2Valid & (w_guard | w_sticky);
        end
    end

    assign out_inexact = r_s3Inexact;
`endif

endmodule

// File: tb/tb_fixedp2floatp_pipe.sv
// Scoreboard bench for fixedp2floatp_pipe: default Q16.16 instance under directed and
// random traffic with back-pressure, plus a Q8.8 instance for the narrow exact path.
module tb_fixedp2floatp_pipe;

    typedef struct packed {
        logic [31:0] f;
        logic        x;
    } expT;

    logic clk = 1'b0;
    logic rst_n;
    logic inValid, inReady, outValid, outReady;
    logic [31:0] inFixed, outFloat;
    logic inValid2, inReady2, outValid2, outReady2;
    logic [15:0] inFixed2;
    logic [31:0] outFloat2;
`ifdef FX2FP_INEXACT_EN
    logic outInexact, outInexact2;
`endif

    int checks = 0;
    int failures = 0;
    expT expQ[$];
    bit held = 1'b0;
    logic [31:0] heldF;

    always #5 clk = ~clk;

    fixedp2floatp_pipe #(.INT_BITS(16), .FRAC_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady), .in_fixed(inFixed),
        .out_valid(outValid), .out_ready(outReady), .out_float(outFloat)
`ifdef FX2FP_INEXACT_EN
        , .out_inexact(outInexact)
`endif
    );

    fixedp2floatp_pipe #(.INT_BITS(8), .FRAC_BITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid2), .in_ready(inReady2), .in_fixed(inFixed2),
        .out_valid(outValid2), .out_ready(outReady2), .out_float(outFloat2)
`ifdef FX2FP_INEXACT_EN
        , .out_inexact(outInexact2)
`endif
    );

    // Value-level reference: round |x| to 24 significant bits by comparing the
    // discarded remainder against one half ulp.
    function automatic expT refModel(input logic [63:0] raw, input int w, input int f);
        expT r;
        logic [63:0] mag, m, rem, half;
        int p, e, sh;
        r = '0;
        mag = raw;
        if (w < 64) mag = raw & ((64'd1 << w) - 64'd1);
        if (raw[w-1]) begin
            mag = ~mag + 64'd1;
            if (w < 64) mag = mag & ((64'd1 << w) - 64'd1);
        end
        if (mag == 64'd0) return r;
        p = 63;
        while (!mag[p]) p--;
        e = 127 + p - f;
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            sh = p - 23;
            m = mag >> sh;
            rem = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            r.x = (rem != 64'd0);
            if (rem > half || (rem == half && m[0])) m = m + 64'd1;
            if (m[24]) begin
                m = m >> 1;
                e = e + 1;
            end
        end
        r.f = {raw[w-1], 8'(e), m[22:0]};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Drives one cycle of inputs and records the expected result of any word accepted.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy,
                                 input bit haveConst, input logic [31:0] cF, input logic cX);
        expT e;
        @(negedge clk);
        inValid = v;
        inFixed = d;
        outReady = rdy;
        #1;
        if (v && inReady) begin
            if (haveConst) e = {cF, cX};
            else e = refModel({32'd0, d}, 32, 16);
            expQ.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks held outputs.
    always begin
        expT e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("stall_valid", {31'd0, outValid}, 32'd1);
                checkOutput("stall_stable", outFloat, heldF);
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output got=%h want=none", outFloat);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_float", outFloat, e.f);
`ifdef FX2FP_INEXACT_EN
                    checkOutput("out_inexact", {31'd0, outInexact}, {31'd0, e.x});
`endif
                end
            end
            held = outValid && !outReady;
            heldF = outFloat;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] d;
        expT e;
        int waitCnt;
        rst_n = 1'b0;
        inValid = 1'b0; inFixed = '0; outReady = 1'b1;
        inValid2 = 1'b0; inFixed2 = '0; outReady2 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset_out_float", outFloat, 32'd0);
        checkOutput("reset_out_valid8", {31'd0, outValid2}, 32'd0);
`ifdef FX2FP_INEXACT_EN
        checkOutput("reset_inexact", {31'd0, outInexact}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", {31'd0, inReady}, 32'd1);

        // Latency: -2.5 appears in the third cycle after it is driven.
        applyStimulus(1'b1, 32'hFFFD_8000, 1'b1, 1'b1, 32'hC020_0000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("latency_valid", {31'd0, outValid}, (c == 3) ? 32'd1 : 32'd0);
        end
        idle(2);

        // Back-to-back stream emerges on consecutive cycles.
        applyStimulus(1'b1, 32'h0001_0000, 1'b1, 1'b1, 32'h3F80_0000, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'hC700_0000, 1'b0);
        applyStimulus(1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("stream_valid", {31'd0, outValid}, (c <= 3) ? 32'd1 : 32'd0);
        end

        // Rounding corner cases.
        applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h4700_0000, 1'b1);
        applyStimulus(1'b1, 32'h0200_0002, 1'b1, 1'b1, 32'h4400_0000, 1'b1);
        applyStimulus(1'b1, 32'h0200_0006, 1'b1, 1'b1, 32'h4400_0002, 1'b1);
        idle(5);

        // Back-pressure with three words in flight.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("stall_in_ready", {31'd0, inReady}, 32'd0);
        end
        idle(6);
        checkOutput("stall_drained", expQ.size(), 32'd0);

        // Reset with two words in flight: both must vanish.
        applyStimulus(1'b1, 32'h0003_0000, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        inValid = 1'b0;
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_valid", {31'd0, outValid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("midreset_no_output", {31'd0, outValid}, 32'd0);
        end

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: d = 32'd0;
                1: d = 32'h8000_0000;
                2: d = 32'h7FFF_FFFF;
                3: d = 32'd1 << $urandom_range(0, 31);
                4: d = $urandom_range(0, 255);
                default: d = $urandom;
            endcase
            applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, 1'b0, 32'd0, 1'b0);
        end
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 50) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
            waitCnt++;
        end
        checkOutput("random_drained", expQ.size(), 32'd0);

        // Narrow Q8.8 instance: always exact.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            inFixed2 = (i == 0) ? 16'hFF80 : 16'($urandom);
            inValid2 = 1'b1;
            e = (i == 0) ? expT'({32'hBF00_0000, 1'b0}) : refModel({48'd0, inFixed2}, 16, 8);
            @(negedge clk);
            inValid2 = 1'b0;
            waitCnt = 0;
            #1;
            while (!outValid2 && waitCnt < 10) begin
                @(negedge clk);
                #1;
                waitCnt++;
            end
            checkOutput("q8_valid", {31'd0, outValid2}, 32'd1);
            checkOutput("q8_float", outFloat2, e.f);
`ifdef FX2FP_INEXACT_EN
            checkOutput("q8_inexact", {31'd0, outInexact2}, 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
